// File: rtl/plab2_proc_mem_port_arbiter_pkg.sv
// Shared definitions for the imem/dmem memory port arbiter: port IDs and
// memory message widths matching the VC_MEM_REQ/RESP_MSG_NBITS layouts.
package plab2_proc_mem_port_arbiter_pkg;

  localparam logic PLAB2_PROC_ARB_PORT_IMEM = 1'b0;
  localparam logic PLAB2_PROC_ARB_PORT_DMEM = 1'b1;

  localparam int unsigned MEM_TYPE_NBITS = 3;
  localparam int unsigned MEM_TEST_NBITS = 2;

  // req = {type, opaque, addr, len, data}
  function automatic int unsigned mem_req_nbits(input int unsigned o, input int unsigned a,
                                                input int unsigned d);
    return MEM_TYPE_NBITS + o + a + $clog2(d / 8) + d;
  endfunction

  // resp = {type, opaque, test, len, data}
  function automatic int unsigned mem_resp_nbits(input int unsigned o, input int unsigned d);
    return MEM_TYPE_NBITS + o + MEM_TEST_NBITS + $clog2(d / 8) + d;
  endfunction

endpackage

// File: rtl/plab2_proc_mem_port_arbiter_id_fifo.sv
// One-bit-wide FIFO holding the port ID of every outstanding memory request,
// oldest at the head. Depth must be a power of two so pointers wrap naturally.
module plab2_proc_ArbIdFifo #(
  parameter int unsigned p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PTR_NB = $clog2(p_depth);
  localparam int unsigned CNT_NB = $clog2(p_depth + 1);

  logic [p_depth-1:0] ids_q, ids_d;
  logic [PTR_NB-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_NB-1:0]  count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == CNT_NB'(p_depth));
  assign empty_o = (count_q == '0);
  assign head_o  = ids_q[head_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    ids_d   = ids_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_ok) begin
      ids_d[tail_q] = push_id_i;
      tail_d        = tail_q + PTR_NB'(1);
    end
    if (pop_ok) begin
      head_d = head_q + PTR_NB'(1);
    end
    count_d = count_q + CNT_NB'(push_ok) - CNT_NB'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ids_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ids_q   <= ids_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/plab2_proc_mem_port_arbiter.sv
// Merges the imem (port 0) and dmem (port 1) request streams onto one memory
// port with round-robin grant, and steers in-order responses back by port ID.
module plab2_proc_mem_port_arbiter
  import plab2_proc_mem_port_arbiter_pkg::*;
#(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_max_out      = 4,
  localparam int unsigned REQ_NB  = mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int unsigned RESP_NB = mem_resp_nbits(p_opaque_nbits, p_data_nbits)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [REQ_NB-1:0]  in0_req_msg,
  input  logic               in0_req_val,
  output logic               in0_req_rdy,
  output logic [RESP_NB-1:0] in0_resp_msg,
  output logic               in0_resp_val,
  input  logic               in0_resp_rdy,

  input  logic [REQ_NB-1:0]  in1_req_msg,
  input  logic               in1_req_val,
  output logic               in1_req_rdy,
  output logic [RESP_NB-1:0] in1_resp_msg,
  output logic               in1_resp_val,
  input  logic               in1_resp_rdy,

  output logic [REQ_NB-1:0]  out_req_msg,
  output logic               out_req_val,
  input  logic               out_req_rdy,
  input  logic [RESP_NB-1:0] out_resp_msg,
  input  logic               out_resp_val,
  output logic               out_resp_rdy
);

  logic prio_q, prio_d;
  logic full, empty, head_id;
  logic grant0, grant1, push_id;
  logic req_fire, resp_fire;

  // Request side: full comes from the registered count only, so nothing on
  // the response side reaches these outputs combinationally.
  assign grant0 = in0_req_val & (~in1_req_val | (prio_q == PLAB2_PROC_ARB_PORT_IMEM));
  assign grant1 = in1_req_val & (~in0_req_val | (prio_q == PLAB2_PROC_ARB_PORT_DMEM));

  assign out_req_val = (in0_req_val | in1_req_val) & ~full;
  assign out_req_msg = grant1 ? in1_req_msg : in0_req_msg;
  assign in0_req_rdy = reset & grant0 & out_req_rdy & ~full;
  assign in1_req_rdy = reset & grant1 & out_req_rdy & ~full;

  assign req_fire = out_req_val & out_req_rdy;
  assign push_id  = grant1 ? PLAB2_PROC_ARB_PORT_DMEM : PLAB2_PROC_ARB_PORT_IMEM;

  always_comb begin
    prio_d = prio_q;
    if (req_fire) begin
      prio_d = ~push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q <= PLAB2_PROC_ARB_PORT_IMEM;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Response side: with nothing outstanding, memory responses are held off.
  assign in0_resp_msg = out_resp_msg;
  assign in1_resp_msg = out_resp_msg;
  assign in0_resp_val = out_resp_val & ~empty & (head_id == PLAB2_PROC_ARB_PORT_IMEM);
  assign in1_resp_val = out_resp_val & ~empty & (head_id == PLAB2_PROC_ARB_PORT_DMEM);
  assign out_resp_rdy = ~empty &
                        ((head_id == PLAB2_PROC_ARB_PORT_DMEM) ? in1_resp_rdy : in0_resp_rdy);
  assign resp_fire    = out_resp_val & out_resp_rdy;

  plab2_proc_ArbIdFifo #(
    .p_depth (p_max_out)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (req_fire),
    .push_id_i (push_id),
    .pop_i     (resp_fire),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head_id)
  );

endmodule

// File: tb/tb_plab2_proc_mem_port_arbiter.sv
// Bench for the imem/dmem port arbiter: a reference model of grant/occupancy
// plus a scoreboard of expected response destinations and memory responses.
module tb_plab2_proc_mem_port_arbiter;
  import plab2_proc_mem_port_arbiter_pkg::*;

  localparam int unsigned O = 8, A = 32, D = 32, MAXO = 4;
  localparam int unsigned REQ_NB  = mem_req_nbits(O, A, D);
  localparam int unsigned RESP_NB = mem_resp_nbits(O, D);

  typedef logic [REQ_NB-1:0]  req_t;
  typedef logic [RESP_NB-1:0] resp_t;
  typedef struct {
    resp_t msg;
    int    t;
  } mem_ent_t;

  localparam resp_t SPUR_MSG = '1;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  req_t  in0_req_msg, in1_req_msg, out_req_msg;
  resp_t in0_resp_msg, in1_resp_msg, out_resp_msg;
  logic  in0_req_val, in0_req_rdy, in0_resp_val, in0_resp_rdy;
  logic  in1_req_val, in1_req_rdy, in1_resp_val, in1_resp_rdy;
  logic  out_req_val, out_req_rdy, out_resp_val, out_resp_rdy;

  always #5 clk = ~clk;

  plab2_proc_mem_port_arbiter #(
    .p_opaque_nbits (O),
    .p_addr_nbits   (A),
    .p_data_nbits   (D),
    .p_max_out      (MAXO)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .in0_req_msg  (in0_req_msg),
    .in0_req_val  (in0_req_val),
    .in0_req_rdy  (in0_req_rdy),
    .in0_resp_msg (in0_resp_msg),
    .in0_resp_val (in0_resp_val),
    .in0_resp_rdy (in0_resp_rdy),
    .in1_req_msg  (in1_req_msg),
    .in1_req_val  (in1_req_val),
    .in1_req_rdy  (in1_req_rdy),
    .in1_resp_msg (in1_resp_msg),
    .in1_resp_val (in1_resp_val),
    .in1_resp_rdy (in1_resp_rdy),
    .out_req_msg  (out_req_msg),
    .out_req_val  (out_req_val),
    .out_req_rdy  (out_req_rdy),
    .out_resp_msg (out_resp_msg),
    .out_resp_val (out_resp_val),
    .out_resp_rdy (out_resp_rdy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Stimulus controls and model state
  logic v0 = 0, v1 = 0, ordy = 1, r0 = 1, r1 = 1, resp_en = 0, spur = 0;
  int   seq0 = 0, seq1 = 0, mem_n = 0, cyc = 0, resp_dly = 0, n_fire = 0;
  int   cnt_m = 0;
  logic prio_m = 1'b0;
  logic last_fire_port = 1'b0;
  logic exp_q[$];
  mem_ent_t mem_q[$];
  int   d0_cnt = 0, d1_cnt = 0;
  logic [31:0] last0 = '0;

  function automatic req_t make_req(input logic port, input int seq);
    logic [7:0]  op;
    logic [31:0] addr, data;
    op   = {port, seq[6:0]};
    addr = 32'h1000 + (port ? 32'h2000 : 32'h0) + 32'(seq) * 4;
    data = port ? 32'h5000 + 32'(seq) : 32'h0;
    return {(port ? 3'd1 : 3'd0), op, addr, 2'd0, data};
  endfunction

  function automatic resp_t make_resp(input req_t r, input int n);
    return {r[76:74], r[73:66], 2'b00, r[33:32], 32'hCAFE0000 + 32'(n)};
  endfunction

  task automatic cycle();
    logic  full_m, g0, g1, qf, rf, h, ovl, pop_rdy;
    req_t  m0, m1, req;
    resp_t drv;
    m0 = make_req(1'b0, seq0);
    m1 = make_req(1'b1, seq1);
    in0_req_msg  = m0;
    in1_req_msg  = m1;
    in0_req_val  = v0;
    in1_req_val  = v1;
    out_req_rdy  = ordy;
    in0_resp_rdy = r0;
    in1_resp_rdy = r1;
    ovl = spur;
    if (resp_en && mem_q.size() > 0) begin
      if (mem_q[0].t <= cyc) ovl = 1'b1;
    end
    drv = spur ? SPUR_MSG : ((mem_q.size() > 0) ? mem_q[0].msg : '0);
    out_resp_val = ovl;
    out_resp_msg = drv;

    h       = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    full_m  = (cnt_m == MAXO);
    g0      = v0 & (~v1 | ~prio_m);
    g1      = v1 & (~v0 | prio_m);
    pop_rdy = (cnt_m > 0) & (h ? r1 : r0);
    qf      = rst_n & (v0 | v1) & ~full_m & ordy;
    rf      = rst_n & ovl & pop_rdy;

    @(negedge clk);
    if (in0_resp_val === 1'b1) begin
      d0_cnt++;
      last0 = in0_resp_msg[31:0];
    end
    if (in1_resp_val === 1'b1) d1_cnt++;
    if (!rst_n) begin
      check_eq("rst_req_rdy0", 128'(in0_req_rdy), 128'(1'b0));
      check_eq("rst_req_rdy1", 128'(in1_req_rdy), 128'(1'b0));
    end else begin
      check_eq("req_val", 128'(out_req_val), 128'((v0 | v1) & ~full_m));
      check_eq("req_rdy0", 128'(in0_req_rdy), 128'(g0 & ordy & ~full_m));
      check_eq("req_rdy1", 128'(in1_req_rdy), 128'(g1 & ordy & ~full_m));
      check_eq("req_msg", 128'(out_req_msg), 128'(g1 ? m1 : m0));
      check_eq("resp_rdy", 128'(out_resp_rdy), 128'(pop_rdy));
      check_eq("resp_val0", 128'(in0_resp_val), 128'(ovl & (cnt_m > 0) & ~h));
      check_eq("resp_val1", 128'(in1_resp_val), 128'(ovl & (cnt_m > 0) & h));
      if (ovl && cnt_m > 0) begin
        if (h) check_eq("resp_msg1", 128'(in1_resp_msg), 128'(drv));
        else   check_eq("resp_msg0", 128'(in0_resp_msg), 128'(drv));
      end
    end

    @(posedge clk);
    if (!rst_n) begin
      cnt_m  = 0;
      prio_m = 1'b0;
      mem_n  = 0;
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (rf) begin
        void'(exp_q.pop_front());
        void'(mem_q.pop_front());
      end
      if (qf) begin
        req = g1 ? m1 : m0;
        exp_q.push_back(g1);
        mem_n++;
        mem_q.push_back('{msg: make_resp(req, mem_n), t: cyc + 1 + resp_dly});
        prio_m = ~g1;
        if (g1) seq1++;
        else    seq0++;
        n_fire++;
        last_fire_port = g1;
      end
      cnt_m = cnt_m + int'(qf) - int'(rf);
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    v0 = 0; v1 = 0; r0 = 1; r1 = 1; resp_en = 1;
    while (cnt_m > 0 && b < 50) begin
      cycle();
      b++;
    end
    check_eq("drain_left", 128'(cnt_m), 128'(0));
  endtask

  initial begin
    int start, b;
    in0_req_msg = '0; in1_req_msg = '0; out_resp_msg = '0;
    in0_req_val = 0; in1_req_val = 0; out_req_rdy = 1;
    in0_resp_rdy = 1; in1_resp_rdy = 1; out_resp_val = 0;
    @(posedge clk);
    #1;

    // Reset held with a valid request present, then idle
    v0 = 1;
    repeat (2) cycle();
    rst_n = 1; v0 = 0;
    repeat (2) cycle();

    // Single imem request, response routed only to port 0
    v0 = 1;
    cycle();
    v0 = 0; d0_cnt = 0; d1_cnt = 0; resp_en = 1;
    repeat (3) cycle();
    check_eq("imem_resp_data", 128'(last0), 128'(32'hCAFE0001));
    check_eq("imem_resp_cnt", 128'(d0_cnt), 128'(1));
    check_eq("dmem_no_resp", 128'(d1_cnt), 128'(0));

    // Both ports always valid: alternating grants, in-order routing
    v0 = 1; v1 = 1;
    repeat (8) cycle();
    drain();

    // Fill to the outstanding limit, then a pop must not free a slot that cycle
    resp_en = 0; v0 = 1; v1 = 1;
    repeat (5) cycle();
    resp_en = 1;
    repeat (2) cycle();
    drain();

    // dmem response back-pressure holds the head
    v1 = 1;
    cycle();
    v1 = 0; r1 = 0; resp_en = 1;
    repeat (3) cycle();
    r1 = 1;
    cycle();
    drain();

    // Pointer wrap with delayed responses, then reset mid-stream
    resp_dly = 2; resp_en = 1; v0 = 1; v1 = 1;
    start = n_fire; b = 0;
    while (n_fire - start < 10 && b < 60) begin
      cycle();
      b++;
    end
    check_eq("wrap_fires", 128'(n_fire - start), 128'(10));
    v1 = 0;
    start = n_fire; b = 0;
    while (n_fire == start && b < 20) begin
      cycle();
      b++;
    end
    check_eq("imem_fire_before_rst", 128'(last_fire_port), 128'(1'b0));
    rst_n = 0; v0 = 1; v1 = 1;
    cycle();
    rst_n = 1; resp_dly = 0; resp_en = 0; spur = 1;
    cycle();
    spur = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
